// File: rtl/mul_add_fn_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency MulAdd unit.
// Credits bound outstanding work so results always fit in the in-order result FIFO.
module mul_add_fn_arbiter #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req0_valid,
  output logic        io_req0_ready,
  input  logic [1:0]  io_req0_bits_op,
  input  logic [32:0] io_req0_bits_a,
  input  logic [32:0] io_req0_bits_b,
  input  logic [32:0] io_req0_bits_c,
  input  logic [2:0]  io_req0_bits_rm,
  input  logic        io_req1_valid,
  output logic        io_req1_ready,
  input  logic [1:0]  io_req1_bits_op,
  input  logic [32:0] io_req1_bits_a,
  input  logic [32:0] io_req1_bits_b,
  input  logic [32:0] io_req1_bits_c,
  input  logic [2:0]  io_req1_bits_rm,
  output logic        io_unit_valid,
  output logic [1:0]  io_unit_op,
  output logic [32:0] io_unit_a,
  output logic [32:0] io_unit_b,
  output logic [32:0] io_unit_c,
  output logic [2:0]  io_unit_rm,
  input  logic        io_unit_out_valid,
  input  logic [32:0] io_unit_out_data,
  input  logic [4:0]  io_unit_out_exc,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic        io_resp_bits_tag,
  output logic [32:0] io_resp_bits_data,
  output logic [4:0]  io_resp_bits_exc,
  output logic        io_busy,
  output logic        io_protocolErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int QW = $clog2(LATENCY + 1);

  logic [CW-1:0]      credit;
  logic [CW-1:0]      count;
  logic               ptr;
  logic               run;
  logic [QW-1:0]      quiet;
  logic [LATENCY-1:0] sr_valid;
  logic [LATENCY-1:0] sr_tag;
  logic [38:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [38:0]        head;
  logic               deq;
  logic               enq;
  logic               can_issue;
  logic               grant0;
  logic               grant1;
  logic               issue;
  logic               err_missing;
  logic               err_extra;

  assign deq = io_resp_valid & io_resp_ready;
  assign enq = sr_valid[LATENCY-1];

  // A dequeue in the same cycle frees the slot, so a full pipe can still issue.
  assign can_issue = run & ((credit != '0) | deq);

  assign grant1 = io_req1_valid & (ptr | ~io_req0_valid);
  assign grant0 = io_req0_valid & ~grant1;

  assign io_req0_ready = can_issue & grant0;
  assign io_req1_ready = can_issue & grant1;
  assign issue         = io_req0_ready | io_req1_ready;
  assign io_unit_valid = issue;

  always_comb begin
    io_unit_op = '0;
    io_unit_a  = '0;
    io_unit_b  = '0;
    io_unit_c  = '0;
    io_unit_rm = '0;
    if (io_req0_ready) begin
      io_unit_op = io_req0_bits_op;
      io_unit_a  = io_req0_bits_a;
      io_unit_b  = io_req0_bits_b;
      io_unit_c  = io_req0_bits_c;
      io_unit_rm = io_req0_bits_rm;
    end else if (io_req1_ready) begin
      io_unit_op = io_req1_bits_op;
      io_unit_a  = io_req1_bits_a;
      io_unit_b  = io_req1_bits_b;
      io_unit_c  = io_req1_bits_c;
      io_unit_rm = io_req1_bits_rm;
    end
  end

  // Strobes from work issued before a reset may land during the quiet window.
  assign err_missing = enq & ~io_unit_out_valid;
  assign err_extra   = io_unit_out_valid & ~enq & (quiet == '0);

  assign head              = mem[rd_ptr];
  assign io_resp_valid     = count != '0;
  assign io_resp_bits_tag  = head[38];
  assign io_resp_bits_data = head[37:5];
  assign io_resp_bits_exc  = head[4:0];
  assign io_busy           = credit != CW'(DEPTH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credit         <= CW'(DEPTH);
      count          <= '0;
      ptr            <= 1'b0;
      run            <= 1'b0;
      quiet          <= QW'(LATENCY);
      sr_valid       <= '0;
      sr_tag         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      io_protocolErr <= 1'b0;
    end else begin
      run <= 1'b1;
      if (quiet != '0) quiet <= quiet - 1'b1;

      if (issue && !deq)      credit <= credit - 1'b1;
      else if (!issue && deq) credit <= credit + 1'b1;

      if (issue) ptr <= io_req0_ready;

      for (int i = LATENCY - 1; i > 0; i--) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_tag[i]   <= sr_tag[i-1];
      end
      sr_valid[0] <= issue;
      sr_tag[0]   <= io_req1_ready;

      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;

      if (err_missing || err_extra) io_protocolErr <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr] <= {sr_tag[LATENCY-1], io_unit_out_data, io_unit_out_exc};
  end

endmodule

// File: tb/tb_mul_add_fn_arbiter.sv
// Bench for mul_add_fn_arbiter: arbitration/credit model, fixed-latency unit model,
// response scoreboard, stimulus tables plus hand sequences for full, error and reset cases.
module tb_mul_add_fn_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_req0_valid = 1'b0, io_req1_valid = 1'b0;
  logic        io_req0_ready, io_req1_ready;
  logic [1:0]  io_req0_bits_op = '0, io_req1_bits_op = '0;
  logic [32:0] io_req0_bits_a = '0, io_req0_bits_b = '0, io_req0_bits_c = '0;
  logic [32:0] io_req1_bits_a = '0, io_req1_bits_b = '0, io_req1_bits_c = '0;
  logic [2:0]  io_req0_bits_rm = '0, io_req1_bits_rm = '0;
  logic        io_unit_valid;
  logic [1:0]  io_unit_op;
  logic [32:0] io_unit_a, io_unit_b, io_unit_c;
  logic [2:0]  io_unit_rm;
  logic        io_unit_out_valid;
  logic [32:0] io_unit_out_data;
  logic [4:0]  io_unit_out_exc;
  logic        io_resp_valid;
  logic        io_resp_ready = 1'b0;
  logic        io_resp_bits_tag;
  logic [32:0] io_resp_bits_data;
  logic [4:0]  io_resp_bits_exc;
  logic        io_busy;
  logic        io_protocolErr;

  mul_add_fn_arbiter #(.LATENCY(3), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready),
    .io_req0_bits_op(io_req0_bits_op), .io_req0_bits_a(io_req0_bits_a),
    .io_req0_bits_b(io_req0_bits_b), .io_req0_bits_c(io_req0_bits_c),
    .io_req0_bits_rm(io_req0_bits_rm),
    .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready),
    .io_req1_bits_op(io_req1_bits_op), .io_req1_bits_a(io_req1_bits_a),
    .io_req1_bits_b(io_req1_bits_b), .io_req1_bits_c(io_req1_bits_c),
    .io_req1_bits_rm(io_req1_bits_rm),
    .io_unit_valid(io_unit_valid), .io_unit_op(io_unit_op),
    .io_unit_a(io_unit_a), .io_unit_b(io_unit_b), .io_unit_c(io_unit_c),
    .io_unit_rm(io_unit_rm),
    .io_unit_out_valid(io_unit_out_valid), .io_unit_out_data(io_unit_out_data),
    .io_unit_out_exc(io_unit_out_exc),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_bits_tag(io_resp_bits_tag), .io_resp_bits_data(io_resp_bits_data),
    .io_resp_bits_exc(io_resp_bits_exc),
    .io_busy(io_busy), .io_protocolErr(io_protocolErr)
  );

  always #5 clock = ~clock;

  function automatic logic [37:0] unit_fn(input logic [1:0] op, input logic [32:0] a,
                                          input logic [32:0] b, input logic [32:0] c,
                                          input logic [2:0] rm);
    return {a ^ {b[0], b[32:1]} ^ (c + 33'(op)), op, rm};
  endfunction

  // Shared unit stand-in: result appears exactly 3 cycles after the issue cycle.
  logic [2:0]  uv = '0;
  logic [37:0] upipe [3];
  logic        inject = 1'b0;

  always @(posedge clock) begin
    uv       <= {uv[1:0], io_unit_valid};
    upipe[0] <= unit_fn(io_unit_op, io_unit_a, io_unit_b, io_unit_c, io_unit_rm);
    upipe[1] <= upipe[0];
    upipe[2] <= upipe[1];
  end

  assign io_unit_out_valid = uv[2] | inject;
  assign io_unit_out_data  = upipe[2][37:5];
  assign io_unit_out_exc   = upipe[2][4:0];

  int n_vec = 0;
  int n_err = 0;
  int dut_issues = 0;

  int       m_credit;
  int       m_cnt;
  logic     m_ptr, m_run, m_perr;
  logic [2:0] m_sr;
  logic [38:0] sb [$];

  typedef struct {
    logic v0, v1, rr, e0, e1;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 4;
    m_cnt    = 0;
    m_ptr    = 1'b0;
    m_run    = 1'b0;
    m_perr   = 1'b0;
    m_sr     = '0;
    sb.delete();
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    io_req0_valid = 1'b1;
    io_req1_valid = 1'b1;
    io_resp_ready = 1'b1;
    model_reset();
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("rst_req0_ready", io_req0_ready, 1'b0);
      chk("rst_req1_ready", io_req1_ready, 1'b0);
      chk("rst_unit_valid", io_unit_valid, 1'b0);
      chk("rst_resp_valid", io_resp_valid, 1'b0);
      chk("rst_busy", io_busy, 1'b0);
      chk("rst_protocol_err", io_protocolErr, 1'b0);
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic step(input logic v0, input logic v1, input logic rr,
                      input bit use_exp, input logic e0, input logic e1);
    logic exp_deq, can, g0, g1, r0, r1, enq;
    logic [38:0] want;
    io_req0_valid   = v0;
    io_req1_valid   = v1;
    io_resp_ready   = rr;
    io_req0_bits_op = 2'($urandom);
    io_req0_bits_a  = {1'($urandom), 32'($urandom)};
    io_req0_bits_b  = {1'($urandom), 32'($urandom)};
    io_req0_bits_c  = {1'($urandom), 32'($urandom)};
    io_req0_bits_rm = 3'($urandom);
    io_req1_bits_op = 2'($urandom);
    io_req1_bits_a  = {1'($urandom), 32'($urandom)};
    io_req1_bits_b  = {1'($urandom), 32'($urandom)};
    io_req1_bits_c  = {1'($urandom), 32'($urandom)};
    io_req1_bits_rm = 3'($urandom);
    @(negedge clock);
    exp_deq = (m_cnt != 0) && rr;
    can     = m_run && ((m_credit != 0) || exp_deq);
    g1      = v1 && (m_ptr || !v0);
    g0      = v0 && !g1;
    r0      = can && g0;
    r1      = can && g1;
    if (use_exp) begin
      r0 = e0;
      r1 = e1;
    end
    chk("req0_ready", io_req0_ready, r0);
    chk("req1_ready", io_req1_ready, r1);
    chk("unit_valid", io_unit_valid, r0 | r1);
    chk("resp_valid", io_resp_valid, m_cnt != 0);
    chk("busy", io_busy, m_credit != 4);
    chk("protocol_err", io_protocolErr, m_perr);
    if (io_req0_ready | io_req1_ready) dut_issues++;
    if (exp_deq) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: dequeue with no expected entry (t=%0t)", $time);
      end else begin
        want = sb.pop_front();
        chk("resp_bits", {io_resp_bits_tag, io_resp_bits_data, io_resp_bits_exc}, want);
      end
    end
    if (r0) begin
      chk("unit_a", io_unit_a, io_req0_bits_a);
      sb.push_back({1'b0, unit_fn(io_req0_bits_op, io_req0_bits_a, io_req0_bits_b,
                                  io_req0_bits_c, io_req0_bits_rm)});
    end else if (r1) begin
      chk("unit_a", io_unit_a, io_req1_bits_a);
      sb.push_back({1'b1, unit_fn(io_req1_bits_op, io_req1_bits_a, io_req1_bits_b,
                                  io_req1_bits_c, io_req1_bits_rm)});
    end else begin
      chk("unit_a_idle", io_unit_a, 33'd0);
    end
    enq = m_sr[2];
    if ((r0 | r1) && !exp_deq) m_credit--;
    else if (!(r0 | r1) && exp_deq) m_credit++;
    if (r0 | r1) m_ptr = r0;
    m_cnt = m_cnt + int'(enq) - int'(exp_deq);
    m_sr  = {m_sr[1:0], r0 | r1};
    if (inject) m_perr = 1'b1;
    m_run = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rr, 1'b0, 1'b0, 1'b0);
  endtask

  int base;

  initial begin
    #3;
    do_reset(2);
    idle(1, 1'b0);

    // Alternating grants under full contention, then single-requester priority cases.
    for (int i = 0; i < 10; i++) tbl.push_back('{1'b1, 1'b1, 1'b1, (i % 2) == 0, (i % 2) == 1});
    for (int i = 0; i < 6; i++) tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < 6; i++) tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].v0, tbl[i].v1, tbl[i].rr, 1'b1, tbl[i].e0, tbl[i].e1);

    // Credit exhaustion with responses stalled, then one issue per dequeue.
    base = dut_issues;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_issue_count", dut_issues - base, 4);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8, 1'b1);

    // Full FIFO: dequeue and issue in the same cycle, credit stays exhausted.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8, 1'b1);

    // Unexpected unit strobe: sticky error, nothing enqueued.
    inject = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    inject = 1'b0;
    idle(4, 1'b1);

    // Reset with two results buffered and two in flight; their strobes land late.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_busy", io_busy, 1'b1);
    do_reset(1);
    idle(4, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
